mv_fetch_unit: RTL
==================

// Module: mv_fetch_unit
// PURPOSE
//  Parametrised matrix/vector operand fetcher for the Euler matrix-vector datapath.
//  Walks an n_rows x n_cols row-major matrix and its n_cols-entry vector from configurable base addresses.
//  Issues paired reads to the dual-port RAM and delivers (mat,vec) operand pairs over a valid/ready stream.
//  Generates its own row/column/last flags, so no external row-finished or done strobes are needed.
// PARAMETERS
//  ADD_SIZE    16  address width, both RAM ports
//  DATA_SIZE   16  data word width
//  DIM_SIZE    8   width of the row/column count and index registers
//  RD_LAT      1   fixed RAM read latency in cycles (>=1)
//  FIFO_DEPTH  4   output buffer entries (>=RD_LAT+1 for one pair/cycle throughput)
// PORTS
//  clk           in   1          rising-edge clock
//  reset         in   1          asynchronous, active-high reset
//  start         in   1          begin a pass; sampled only in IDLE
//  mat_base      in   ADD_SIZE   matrix element (0,0) address, latched on start
//  vec_base      in   ADD_SIZE   vector element 0 address, latched on start
//  n_rows        in   DIM_SIZE   row count, latched on start
//  n_cols        in   DIM_SIZE   column count, latched on start
//  busy          out  1          high from accepted start until done
//  done          out  1          one-cycle pulse at pass end
//  mem_rd_en     out  1          read strobe, both ports
//  mem_mat_addr  out  ADD_SIZE   matrix read address
//  mem_vec_addr  out  ADD_SIZE   vector read address
//  mem_mat_data  in   DATA_SIZE  matrix data, valid RD_LAT cycles after mem_rd_en
//  mem_vec_data  in   DATA_SIZE  vector data, same timing
//  out_valid     out  1          operand pair available
//  out_ready     in   1          consumer accepts the pair when valid&&ready
//  out_mat       out  DATA_SIZE  matrix operand
//  out_vec       out  DATA_SIZE  vector operand
//  out_last_col  out  1          pair is the last column of its row
//  out_last_row  out  1          pair belongs to the last row (with last_col: final pair)
// BEHAVIOUR
//  - Reset: FSM=IDLE; busy, done, mem_rd_en and out_valid = 0; addresses, counters and FIFO cleared. Async reset mid-pass aborts the pass at once.
//  - FSM IDLE -> ISSUE: on start. Config is latched, mat_ptr=mat_base, vec_ptr=vec_base, r=c=0, busy=1 the next cycle.
//  - start with n_rows==0 or n_cols==0: no reads; done pulses the next cycle; FSM stays IDLE.
//  - ISSUE: issue (mem_rd_en=1) in a cycle only if fifo_count + inflight < FIFO_DEPTH.
//    - Each issue: mat_ptr+=1, c+=1.
//    - At c==n_cols-1: c=0, vec_ptr=vec_base, r+=1. Otherwise vec_ptr+=1.
//    - After issuing (n_rows-1, n_cols-1): ISSUE -> DRAIN.
//  - Address arithmetic is modulo 2^ADD_SIZE: base+offset wraps silently.
//  - In-flight tracking: an RD_LAT-deep shift register carries {valid, last_col, last_row}. The tag is pushed into the FIFO with the RAM data RD_LAT cycles after issue.
//  - Output: FIFO head drives out_*. out_valid = !empty. Payload holds stable while valid&&!ready.
//  - Push and pop in the same cycle are legal at any occupancy. The credit rule guarantees no overflow.
//  - DRAIN -> IDLE: on handshake of the pair with last_row&&last_col. done=1 and busy=0 in the following cycle.
//  - A start in the done cycle is accepted (FSM already IDLE). start while busy is ignored.
//  - Config inputs may change freely after start; only the latched copies are used.
//  - Throughput: one pair per cycle with out_ready held high. First out_valid appears RD_LAT+1 cycles after start.
// STRUCTURE
//  - mv_fetch_defs.vh: FSM state localparams (IDLE/ISSUE/DRAIN) and the tag-width constant.
//  - One sub-module: fetch_out_fifo (synchronous FIFO, width DATA_SIZE*2+2, depth FIFO_DEPTH, full/empty/count).
//  - The rest (FSM, pointers, counters, latency pipe) stays in this module.
// TESTING
//  1. mat_base=0x0032, vec_base=0x0000, 2x3, ready=1 -> mat addrs 32..37, vec addrs 0,1,2,0,1,2; last_col on pairs 3 and 6; done one cycle after pair 6.
//  2. Same pass with out_ready toggling 1,0,0,1 -> no pair lost or duplicated; payload stable while stalled; inflight+count never exceeds FIFO_DEPTH.
//  3. start with n_cols=0 -> mem_rd_en never asserts; done pulses the next cycle; busy stays 0.
//  4. mat_base=0xFFFE, 1x4 -> mat addrs FFFE, FFFF, 0000, 0001.
//  5. reset asserted mid-pass (after 5 issues of 4x4) -> outputs 0 in the same cycle; a new start then runs a full clean pass.
//  6. RD_LAT=3, FIFO_DEPTH=4, 3x3, ready=1 -> 9 back-to-back pairs; first out_valid 4 cycles after start; start in the done cycle begins a second pass.

Source files
------------

// File: rtl/mv_fetch_unit_pkg.sv
// Shared types for the matrix/vector operand fetcher.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mv_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Flag bits that travel with each operand pair: last_col, last_row.
  localparam int FLAG_W = 2;

  // Tag carried through the read-latency pipe alongside each issued read.
  typedef struct packed {
    logic vld;
    logic last_col;
    logic last_row;
  } tag_t;

endpackage

// File: rtl/fetch_out_fifo.sv
// Synchronous output buffer for fetched operand pairs; head entry is always visible.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push when full is dropped unless a pop happens in the same cycle.
// Ports: clk/reset, push + push_dat, pop, head_dat, full, empty, count.
module fetch_out_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/mv_fetch_unit.sv
// Walks an n_rows x n_cols row-major matrix plus its vector and streams (mat,vec) pairs.
// Latency: first out_valid RD_LAT+1 cycles after the start edge; one pair/cycle when ready.
// Backpressure: reads are issued only while buffered + in-flight pairs fit the output FIFO.
// Ports: start/config (latched on start), busy/done status, dual RAM read port
// (mem_rd_en, mem_*_addr, mem_*_data), and the out_* valid/ready pair stream.
module mv_fetch_unit
  import mv_fetch_unit_pkg::*;
#(
  parameter int ADD_SIZE   = 16,
  parameter int DATA_SIZE  = 16,
  parameter int DIM_SIZE   = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADD_SIZE-1:0]  mat_base,
  input  logic [ADD_SIZE-1:0]  vec_base,
  input  logic [DIM_SIZE-1:0]  n_rows,
  input  logic [DIM_SIZE-1:0]  n_cols,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd_en,
  output logic [ADD_SIZE-1:0]  mem_mat_addr,
  output logic [ADD_SIZE-1:0]  mem_vec_addr,
  input  logic [DATA_SIZE-1:0] mem_mat_data,
  input  logic [DATA_SIZE-1:0] mem_vec_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_mat,
  output logic [DATA_SIZE-1:0] out_vec,
  output logic                 out_last_col,
  output logic                 out_last_row
);

  localparam int FW = 2 * DATA_SIZE + FLAG_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [DIM_SIZE-1:0] DIM_ONE = DIM_SIZE'(1);
  localparam logic [ADD_SIZE-1:0] ADD_ONE = ADD_SIZE'(1);

  state_t state_q, state_d;
  logic   done_q, done_d;
  logic   accept;
  logic   issue;

  logic [ADD_SIZE-1:0] mat_ptr_q, vec_ptr_q, vec_base_q;
  logic [DIM_SIZE-1:0] n_rows_q, n_cols_q, row_q, col_q;
  logic                at_last_col, at_last_row;

  tag_t         pipe_q [RD_LAT];
  logic [31:0]  inflight;
  logic [31:0]  outstanding;
  logic         credit_ok;

  logic          pop;
  logic [FW-1:0] head_dat;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign at_last_col = (col_q == n_cols_q - DIM_ONE);
  assign at_last_row = (row_q == n_rows_q - DIM_ONE);

  assign pop = out_valid && out_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 32'(pipe_q[i].vld);
  end

  // A pop in this cycle frees its slot before the new read's data can land,
  // so it is credited immediately; this is what keeps one pair per cycle
  // sustainable with FIFO_DEPTH = RD_LAT + 1.
  assign outstanding = 32'(fifo_count) + inflight - 32'(pop);
  assign credit_ok   = (outstanding < 32'(FIFO_DEPTH)) && (!fifo_full || pop);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (n_rows == '0 || n_cols == '0) begin
            done_d = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (at_last_col && at_last_row) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && out_last_col && out_last_row) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mat_ptr_q  <= '0;
      vec_ptr_q  <= '0;
      vec_base_q <= '0;
      n_rows_q   <= '0;
      n_cols_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else if (accept) begin
      mat_ptr_q  <= mat_base;
      vec_ptr_q  <= vec_base;
      vec_base_q <= vec_base;
      n_rows_q   <= n_rows;
      n_cols_q   <= n_cols;
      row_q      <= '0;
      col_q      <= '0;
    end else if (issue) begin
      // The matrix is contiguous; the vector restarts at its base every row.
      mat_ptr_q <= mat_ptr_q + ADD_ONE;
      if (at_last_col) begin
        col_q     <= '0;
        row_q     <= row_q + DIM_ONE;
        vec_ptr_q <= vec_base_q;
      end else begin
        col_q     <= col_q + DIM_ONE;
        vec_ptr_q <= vec_ptr_q + ADD_ONE;
      end
    end
  end

  // Tag pipe mirrors the RAM latency so flags meet their data at the FIFO input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{vld: issue, last_col: at_last_col, last_row: at_last_row};
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  fetch_out_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pipe_q[RD_LAT-1].vld),
    .push_dat ({mem_mat_data, mem_vec_data,
                pipe_q[RD_LAT-1].last_col, pipe_q[RD_LAT-1].last_row}),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign mem_rd_en    = issue;
  assign mem_mat_addr = mat_ptr_q;
  assign mem_vec_addr = vec_ptr_q;
  assign out_valid    = !fifo_empty;
  assign {out_mat, out_vec, out_last_col, out_last_row} = head_dat;

endmodule
